// File: rtl/cordic_pipe.sv
// rtl/cordic_pipe.sv - pipelined CORDIC rotator/vectorer with valid/ready flow control
module cordic_pipe #(
  parameter int XW     = 16,
  parameter int AW     = 32,
  parameter int STAGES = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          mode,
  input  logic [XW-1:0] xin,
  input  logic [XW-1:0] yin,
  input  logic [AW-1:0] angle,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [XW-1:0] xout,
  output logic [XW-1:0] yout,
  output logic [AW-1:0] zout
);

  // Two guard bits cover the pre-rotation negation plus the ~1.65 CORDIC gain.
  localparam int IW = XW + 2;
  localparam logic [AW-1:0] QUARTER     = {2'b01, {(AW-2){1'b0}}};
  localparam logic [AW-1:0] NEG_QUARTER = {2'b11, {(AW-2){1'b0}}};
  localparam real TWO_PI = 6.283185307179586;

  logic                 w_en;
  logic signed [IW-1:0] w_xin_e;
  logic signed [IW-1:0] w_yin_e;
  logic signed [IW-1:0] w_pre_x;
  logic signed [IW-1:0] w_pre_y;
  logic [AW-1:0]        w_pre_z;

  // Index i holds the operands entering iteration stage i; index 0 is the pre-rotation register.
  logic signed [IW-1:0] r_x    [STAGES];
  logic signed [IW-1:0] r_y    [STAGES];
  logic [AW-1:0]        r_z    [STAGES];
  logic                 r_mode [STAGES];
  logic                 r_v    [STAGES];

  logic signed [IW-1:0] w_nx [STAGES];
  logic signed [IW-1:0] w_ny [STAGES];
  logic [AW-1:0]        w_nz [STAGES];

  logic                 r_out_valid;
  logic [XW-1:0]        r_xout;
  logic [XW-1:0]        r_yout;
  logic [AW-1:0]        r_zout;

  // Clamp the widened result back into the XW-bit signed output range.
  function automatic logic [XW-1:0] sat(input logic signed [IW-1:0] v);
    logic [2:0] top;
    top = v[IW-1:XW-1];
    if ((top == 3'b000) || (top == 3'b111)) begin
      return v[XW-1:0];
    end else if (v[IW-1]) begin
      return {1'b1, {(XW-1){1'b0}}};
    end else begin
      return {1'b0, {(XW-1){1'b1}}};
    end
  endfunction

  // The whole pipeline advances together; it only freezes when a result is waiting unread.
  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;

  assign w_xin_e = {{2{xin[XW-1]}}, xin};
  assign w_yin_e = {{2{yin[XW-1]}}, yin};

  // Pre-rotation folds the input into the +/-90 deg range the iterations can converge over.
  always_comb begin
    w_pre_x = w_xin_e;
    w_pre_y = w_yin_e;
    w_pre_z = mode ? '0 : angle;
    if (!mode) begin
      case (angle[AW-1:AW-2])
        2'b01: begin
          w_pre_x = -w_yin_e;
          w_pre_y = w_xin_e;
          w_pre_z = angle - QUARTER;
        end
        2'b10: begin
          w_pre_x = w_yin_e;
          w_pre_y = -w_xin_e;
          w_pre_z = angle + QUARTER;
        end
        default: begin
          w_pre_x = w_xin_e;
          w_pre_y = w_yin_e;
          w_pre_z = angle;
        end
      endcase
    end else if (xin[XW-1]) begin
      if (!yin[XW-1]) begin
        w_pre_x = w_yin_e;
        w_pre_y = -w_xin_e;
        w_pre_z = QUARTER;
      end else begin
        w_pre_x = -w_yin_e;
        w_pre_y = w_xin_e;
        w_pre_z = NEG_QUARTER;
      end
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    // Elementary angle atan(2^-i) scaled to circle units, folded at elaboration time.
    localparam real     ANG_SCL = $atan(1.0 / (2.0 ** i)) / TWO_PI * (2.0 ** AW);
    localparam longint  ATAN_L  = longint'(ANG_SCL);
    localparam logic [AW-1:0] ATAN = ATAN_L[AW-1:0];

    logic w_dir;
    // w_dir=1 means d=+1: rotate toward driving z to zero, or y to zero when vectoring.
    assign w_dir   = r_mode[i] ? r_y[i][IW-1] : ~r_z[i][AW-1];
    assign w_nx[i] = w_dir ? (r_x[i] - (r_y[i] >>> i)) : (r_x[i] + (r_y[i] >>> i));
    assign w_ny[i] = w_dir ? (r_y[i] + (r_x[i] >>> i)) : (r_y[i] - (r_x[i] >>> i));
    assign w_nz[i] = w_dir ? (r_z[i] - ATAN) : (r_z[i] + ATAN);
  end

  // Valid bits ride alongside the data so bubbles keep their slot through the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_v[i] <= 1'b0;
      end
    end else if (w_en) begin
      r_v[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) begin
        r_v[i] <= r_v[i-1];
      end
    end
  end

  // Data and mode shift forward with the pipeline; contents under a cleared valid are don't-care.
  always_ff @(posedge clk) begin
    if (w_en) begin
      r_x[0]    <= w_pre_x;
      r_y[0]    <= w_pre_y;
      r_z[0]    <= w_pre_z;
      r_mode[0] <= mode;
      for (int i = 1; i < STAGES; i++) begin
        r_x[i]    <= w_nx[i-1];
        r_y[i]    <= w_ny[i-1];
        r_z[i]    <= w_nz[i-1];
        r_mode[i] <= r_mode[i-1];
      end
    end
  end

  // The last iteration writes straight into the saturated output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_xout      <= '0;
      r_yout      <= '0;
      r_zout      <= '0;
    end else if (w_en) begin
      r_out_valid <= r_v[STAGES-1];
      if (r_v[STAGES-1]) begin
        r_xout <= sat(w_nx[STAGES-1]);
        r_yout <= sat(w_ny[STAGES-1]);
        r_zout <= w_nz[STAGES-1];
      end
    end
  end

  assign out_valid = r_out_valid;
  assign xout      = r_xout;
  assign yout      = r_yout;
  assign zout      = r_zout;

endmodule

// File: tb/tb_cordic_pipe.sv
// tb/tb_cordic_pipe.sv - self-checking bench for cordic_pipe against a floating-point model
module tb_cordic_pipe;

  localparam int XW     = 16;
  localparam int AW     = 32;
  localparam int STAGES = 16;
  localparam real TWO_PI = 6.283185307179586;
  localparam real CIRCLE = 4294967296.0;
  localparam longint TOL_XY = 12;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          mode;
  logic [XW-1:0] xin;
  logic [XW-1:0] yin;
  logic [AW-1:0] angle;
  logic          out_valid;
  logic          out_ready;
  logic [XW-1:0] xout;
  logic [XW-1:0] yout;
  logic [AW-1:0] zout;

  typedef struct {
    logic        m;
    int          x;
    int          y;
    logic [31:0] a;
  } samp_t;

  samp_t exp_q[$];
  int    n_vec = 0;
  int    n_mis = 0;
  int    n_out = 0;

  cordic_pipe #(.XW(XW), .AW(AW), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .xin       (xin),
    .yin       (yin),
    .angle     (angle),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xout      (xout),
    .yout      (yout),
    .zout      (zout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_near(input string tag, input longint obs, input longint expv, input longint tol);
    n_vec++;
    assert (((obs >= expv - tol) && (obs <= expv + tol)) === 1'b1)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, expv, tol);
    end
  endtask

  task automatic chk_z(input string tag, input logic [31:0] obs, input logic [31:0] expv, input longint tol);
    logic [31:0] d;
    longint      sd;
    d  = obs - expv;
    sd = longint'($signed(d));
    n_vec++;
    assert (((sd >= -tol) && (sd <= tol)) === 1'b1)
    else begin
      n_mis++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h +/- 0x%0h", tag, obs, expv, tol);
    end
  endtask

  function automatic real kgain();
    real k;
    k = 1.0;
    for (int i = 0; i < STAGES; i++) k = k * $sqrt(1.0 + 1.0 / (4.0 ** i));
    return k;
  endfunction

  function automatic longint clamp(input real v);
    longint r;
    r = longint'(v);
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  // Ideal rotation/vectoring scaled by the uncompensated gain.
  task automatic ref_model(input samp_t s, output longint ex, output longint ey,
                           output logic [31:0] ez, output longint tz);
    real k, th, fx, fy, r, zz;
    longint zl;
    k  = kgain();
    fx = real'(s.x);
    fy = real'(s.y);
    if (!s.m) begin
      th = real'($signed(s.a)) * TWO_PI / CIRCLE;
      ex = clamp(k * (fx * $cos(th) - fy * $sin(th)));
      ey = clamp(k * (fx * $sin(th) + fy * $cos(th)));
      ez = 32'h0;
      tz = 65536;
    end else begin
      r  = $sqrt(fx * fx + fy * fy);
      zz = $atan2(fy, fx) / TWO_PI * CIRCLE;
      zl = longint'(zz);
      ex = clamp(k * r);
      ey = 0;
      ez = zl[31:0];
      tz = 65536 + longint'(8.0 / (k * r) * CIRCLE / TWO_PI);
    end
  endtask

  function automatic samp_t rand_samp();
    samp_t s;
    s.m = 1'($urandom_range(0, 1));
    s.a = $urandom;
    if (!s.m) begin
      s.x = int'($urandom_range(0, 40000)) - 20000;
      s.y = int'($urandom_range(0, 40000)) - 20000;
    end else begin
      do begin
        s.x = int'($urandom_range(0, 60000)) - 30000;
        s.y = int'($urandom_range(0, 60000)) - 30000;
      end while (s.x * s.x + s.y * s.y < 16000000);
    end
    return s;
  endfunction

  // Output monitor: protocol rules plus in-order scoreboard against the model.
  samp_t         m_s;
  longint        m_ex, m_ey, m_tz;
  logic [31:0]   m_ez;
  logic          prev_stall = 1'b0;
  logic [XW-1:0] hx, hy;
  logic [AW-1:0] hz;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (!out_valid) chk_near("in_ready_idle", longint'(in_ready), 1, 0);
      else if (!out_ready) chk_near("in_ready_stall", longint'(in_ready), 0, 0);
      if (prev_stall) begin
        chk_near("hold_valid", longint'(out_valid), 1, 0);
        chk_near("hold_x", longint'($signed(xout)), longint'($signed(hx)), 0);
        chk_near("hold_y", longint'($signed(yout)), longint'($signed(hy)), 0);
        chk_z("hold_z", zout, hz, 0);
      end
      if (out_valid && out_ready) begin
        chk_near("out_expected", longint'(exp_q.size() > 0), 1, 0);
        if (exp_q.size() > 0) begin
          m_s = exp_q.pop_front();
          ref_model(m_s, m_ex, m_ey, m_ez, m_tz);
          chk_near("out_x", longint'($signed(xout)), m_ex, TOL_XY);
          chk_near("out_y", longint'($signed(yout)), m_ey, TOL_XY);
          chk_z("out_z", zout, m_ez, m_tz);
          n_out++;
        end
      end
      prev_stall = out_valid && !out_ready;
      hx = xout;
      hy = yout;
      hz = zout;
    end
  end

  // One cycle of input drive, entered and left at posedge+1.
  task automatic drive_cycle(input logic v, input samp_t s, output logic acc);
    in_valid = v;
    mode     = s.m;
    xin      = 16'(s.x);
    yin      = 16'(s.y);
    angle    = s.a;
    #1;
    acc = v && in_ready;
    if (acc) exp_q.push_back(s);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input samp_t s);
    logic acc;
    int   t;
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 200) begin
      drive_cycle(1'b1, s, acc);
      t++;
    end
    chk_near("send_accepted", longint'(acc), 1, 0);
  endtask

  task automatic idle(input int n);
    samp_t z;
    logic  acc;
    z = '{1'b0, 0, 0, 32'h0};
    for (int i = 0; i < n; i++) drive_cycle(1'b0, z, acc);
  endtask

  task automatic drain();
    int b;
    b = 0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && b < 300) begin
      idle(1);
      b++;
    end
    chk_near("drain_empty", longint'(exp_q.size()), 0, 0);
    idle(2);
  endtask

  // Single sample into an empty pipe; checks latency and the fixed expected result.
  task automatic directed(input string tag, input samp_t s, input longint ex, input longint ey,
                          input logic [31:0] ez, input longint tol_xy, input longint tol_z);
    int lat;
    logic acc;
    out_ready = 1'b1;
    drive_cycle(1'b1, s, acc);
    chk_near({tag, "_acc"}, longint'(acc), 1, 0);
    lat = 1;
    while (!out_valid && lat < 100) begin
      idle(1);
      lat++;
    end
    chk_near({tag, "_latency"}, lat, STAGES + 1, 0);
    chk_near({tag, "_x"}, longint'($signed(xout)), ex, tol_xy);
    chk_near({tag, "_y"}, longint'($signed(yout)), ey, tol_xy);
    chk_z({tag, "_z"}, zout, ez, tol_z);
    drain();
  endtask

  initial begin
    samp_t s;
    logic  acc;
    int    c, k, n0;
    samp_t bp[40];

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mode      = 1'b0;
    xin       = '0;
    yin       = '0;
    angle     = '0;
    @(posedge clk);
    #1;
    chk_near("rst_out_valid", longint'(out_valid), 0, 0);
    chk_near("rst_in_ready", longint'(in_ready), 1, 0);
    chk_near("rst_xout", longint'($signed(xout)), 0, 0);
    chk_near("rst_yout", longint'($signed(yout)), 0, 0);
    chk_z("rst_zout", zout, 32'h0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Directed cases with their fixed results.
    directed("rot45",  '{1'b0, 10000, 0, 32'h2000_0000}, 11645, 11645, 32'h0, 4, 65536);
    directed("rot90",  '{1'b0, 10000, 0, 32'h4000_0000}, 0, 16468, 32'h0, 4, 65536);
    directed("sat",    '{1'b0, 32000, 32000, 32'h2000_0000}, 0, 32767, 32'h0, 4, 65536);
    chk_near("sat_y_exact", longint'($signed(yout)), 32767, 0);
    directed("vec",    '{1'b1, -10000, -10000, 32'h0}, 23289, 0, 32'hA000_0000, 4, 65536);

    // Random samples with random bubbles and random back-pressure.
    for (int i = 0; i < 30; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) idle(1);
      else begin
        s = rand_samp();
        out_ready = ($urandom_range(0, 3) != 0);
        drive_cycle(1'b1, s, acc);
        while (!acc) begin
          out_ready = ($urandom_range(0, 1) != 0);
          drive_cycle(1'b1, s, acc);
        end
      end
    end
    drain();

    // 40 back-to-back samples with a 10-cycle out_ready drop mid-stream.
    for (int i = 0; i < 40; i++) bp[i] = rand_samp();
    n0 = n_out;
    c  = 0;
    k  = 0;
    while (k < 40 && c < 400) begin
      out_ready = !(c >= 20 && c < 30);
      drive_cycle(1'b1, bp[k], acc);
      if (acc) k++;
      c++;
    end
    chk_near("bp_all_sent", k, 40, 0);
    drain();
    chk_near("bp_delivered", n_out - n0, 40, 0);

    // Reset with 5 samples in flight: nothing stale may emerge afterwards.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(rand_samp());
    in_valid = 1'b0;
    rst_n    = 1'b0;
    exp_q.delete();
    #1;
    chk_near("midrst_out_valid", longint'(out_valid), 0, 0);
    chk_near("midrst_in_ready", longint'(in_ready), 1, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n0 = n_out;
    idle(STAGES + 8);
    chk_near("midrst_no_stale", n_out - n0, 0, 0);
    send('{1'b0, 12000, -3000, 32'hC000_0000});
    drain();
    chk_near("midrst_fresh", n_out - n0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
